// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, defaults and address field helpers for set_assoc_cache
package cache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_SETS   = 16;
    localparam int WAYS       = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS_RD = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

    // Addresses are passed zero-extended to 64 bits so one helper serves any ADDR_W.
    function automatic logic [63:0] addr_index(input logic [63:0] a, input int off_w, input int idx_w);
        return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one cache way: valid bits, tags and data words with one write port
module cache_way_array #(
    parameter int SETS   = 16,
    parameter int TAG_W  = 25,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(SETS)-1:0]  w_idx,
    input  logic [TAG_W-1:0]         w_tag,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [$clog2(SETS)-1:0]  r_idx,
    output logic                     r_valid,
    output logic [TAG_W-1:0]         r_tag,
    output logic [DATA_W-1:0]        r_data
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags and data need no reset; they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= w_data;
        end
    end

    assign r_valid = valid_q[r_idx];
    assign r_tag   = tag_q[r_idx];
    assign r_data  = data_q[r_idx];

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - 2-way set-associative write-through, no-write-allocate cache controller
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETS   = DEF_SETS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              hit,
    output logic              stall,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    input  logic              mem_wr_ack
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        logic [63:0] f;
        f = addr_index(64'(a), OFF_W, IDX_W);
        return f[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        logic [63:0] f;
        f = addr_tag(64'(a), OFF_W, IDX_W);
        return f[TAG_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               hit_q, hit_d;
    logic               stall_q, stall_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic [SETS-1:0]    lru_q, lru_d;

    logic [ADDR_W-1:0]  look_addr;
    logic [IDX_W-1:0]   look_idx;
    logic [TAG_W-1:0]   look_tag;
    logic [WAYS-1:0]    way_we;
    logic [DATA_W-1:0]  w_data;
    logic               r_valid [WAYS];
    logic [TAG_W-1:0]   r_tag   [WAYS];
    logic [DATA_W-1:0]  r_data  [WAYS];
    logic               way0_hit, way1_hit, any_hit, hit_way, victim;

    // Outside IDLE the latched (aligned) request address drives the lookup.
    assign look_addr = (state_q == IDLE) ? addr : mem_addr_q;
    assign look_idx  = idx_of(look_addr);
    assign look_tag  = tag_of(look_addr);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clk     (clk),
            .rst_n   (rst),
            .we      (way_we[w]),
            .w_idx   (look_idx),
            .w_tag   (look_tag),
            .w_data  (w_data),
            .r_idx   (look_idx),
            .r_valid (r_valid[w]),
            .r_tag   (r_tag[w]),
            .r_data  (r_data[w])
        );
    end

    assign way0_hit = r_valid[0] && (r_tag[0] == look_tag);
    assign way1_hit = r_valid[1] && (r_tag[1] == look_tag);
    assign any_hit  = way0_hit || way1_hit;
    assign hit_way  = way1_hit;
    assign victim   = !r_valid[0] ? 1'b0 : (!r_valid[1] ? 1'b1 : lru_q[look_idx]);

    always_comb begin
        state_d       = state_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        hit_d         = 1'b0;
        stall_d       = stall_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        lru_d         = lru_q;
        way_we        = '0;
        w_data        = wr_data;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d       = WR_MEM;
                    stall_d       = 1'b1;
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = align(addr);
                    mem_wr_data_d = wr_data;
                    if (any_hit) begin
                        way_we[hit_way] = 1'b1;
                        lru_d[look_idx] = ~hit_way;
                        hit_d           = 1'b1;
                    end
                end else if (rd_en) begin
                    if (any_hit) begin
                        rd_data_d       = r_data[hit_way];
                        rd_valid_d      = 1'b1;
                        hit_d           = 1'b1;
                        lru_d[look_idx] = ~hit_way;
                    end else begin
                        state_d     = MISS_RD;
                        stall_d     = 1'b1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = align(addr);
                    end
                end
            end
            MISS_RD: begin
                if (mem_data_valid) begin
                    way_we[victim]  = 1'b1;
                    w_data          = mem_data;
                    lru_d[look_idx] = ~victim;
                    rd_data_d       = mem_data;
                    rd_valid_d      = 1'b1;
                    mem_rd_en_d     = 1'b0;
                    stall_d         = 1'b0;
                    state_d         = IDLE;
                end
            end
            WR_MEM: begin
                if (mem_wr_ack) begin
                    mem_wr_en_d = 1'b0;
                    stall_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                stall_d     = 1'b0;
                mem_rd_en_d = 1'b0;
                mem_wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            hit_q         <= 1'b0;
            stall_q       <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            lru_q         <= '0;
        end else begin
            state_q       <= state_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            hit_q         <= hit_d;
            stall_q       <= stall_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            lru_q         <= lru_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign hit         = hit_q;
    assign stall       = stall_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - randomized self-checking bench for set_assoc_cache against a recency-list model
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        hit;
    logic        stall;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [63:0] mem_data = '0;
    logic        mem_data_valid = 1'b0;
    logic        mem_wr_ack = 1'b0;

    set_assoc_cache #(.ADDR_W(32), .DATA_W(64), .SETS(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .hit            (hit),
        .stall          (stall),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .mem_wr_ack     (mem_wr_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each set holds up to two lines, element 0 most recently used.
    logic [31:0] m_tag [16][2];
    logic [63:0] m_dat [16][2];
    int          m_cnt [16];
    logic [63:0] mem [logic [31:0]];
    logic [63:0] last_rd = '0;

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 8) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 128;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a - (a % 8);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
        last_rd = '0;
    endtask

    task automatic model_find(input logic [31:0] a, output int pos);
        int s;
        s = set_of(a);
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == tag_of(a)) pos = i;
    endtask

    task automatic model_touch(input int s, input int pos);
        logic [31:0] t;
        logic [63:0] d;
        t = m_tag[s][pos];
        d = m_dat[s][pos];
        for (int i = pos; i > 0; i--) begin
            m_tag[s][i] = m_tag[s][i-1];
            m_dat[s][i] = m_dat[s][i-1];
        end
        m_tag[s][0] = t;
        m_dat[s][0] = d;
    endtask

    task automatic model_insert(input int s, input logic [31:0] t, input logic [63:0] d);
        if (m_cnt[s] < 2) m_cnt[s]++;
        for (int i = m_cnt[s] - 1; i > 0; i--) begin
            m_tag[s][i] = m_tag[s][i-1];
            m_dat[s][i] = m_dat[s][i-1];
        end
        m_tag[s][0] = t;
        m_dat[s][0] = d;
    endtask

    task automatic mem_get(input logic [31:0] w, output logic [63:0] d);
        if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
        d = mem[w];
    endtask

    // Entered and left just after a falling edge.
    task automatic do_read(input logic [31:0] a, output bit got_hit);
        int pos;
        int s;
        int lat;
        logic [63:0] d;
        s = set_of(a);
        model_find(a, pos);
        addr = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        addr = $urandom;
        got_hit = hit;
        if (pos >= 0) begin
            chk("rd_hit_flag", hit, 1);
            chk("rd_hit_valid", rd_valid, 1);
            chk("rd_hit_data", rd_data, m_dat[s][pos]);
            chk("rd_hit_stall", stall, 0);
            chk("rd_hit_memrd", mem_rd_en, 0);
            last_rd = m_dat[s][pos];
            model_touch(s, pos);
        end else begin
            chk("rd_miss_flag", hit, 0);
            chk("rd_miss_valid", rd_valid, 0);
            chk("rd_miss_stall", stall, 1);
            chk("rd_miss_memrd", mem_rd_en, 1);
            chk("rd_miss_addr", mem_addr, word_of(a));
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                mem_wr_ack = $urandom_range(0, 1);
                @(negedge clk);
                chk("rd_miss_hold", {stall, mem_rd_en, rd_valid}, 3'b110);
            end
            mem_wr_ack = 1'b0;
            mem_get(word_of(a), d);
            mem_data = d;
            mem_data_valid = 1'b1;
            @(negedge clk);
            mem_data_valid = 1'b0;
            mem_data = $urandom;
            chk("rd_fill_valid", rd_valid, 1);
            chk("rd_fill_hit", hit, 0);
            chk("rd_fill_stall", {stall, mem_rd_en}, 2'b00);
            chk("rd_fill_data", rd_data, d);
            last_rd = d;
            model_insert(s, tag_of(a), d);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input bit both, output bit got_hit);
        int pos;
        int s;
        int lat;
        s = set_of(a);
        model_find(a, pos);
        addr = a;
        wr_data = d;
        wr_en = 1'b1;
        rd_en = both;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr = $urandom;
        wr_data = {$urandom, $urandom};
        got_hit = hit;
        chk("wr_hit_flag", hit, (pos >= 0) ? 1 : 0);
        chk("wr_rd_valid", rd_valid, 0);
        chk("wr_stall", {stall, mem_wr_en, mem_rd_en}, 3'b110);
        chk("wr_addr", mem_addr, word_of(a));
        chk("wr_data", mem_wr_data, d);
        chk("wr_rd_stable", rd_data, last_rd);
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            mem_data_valid = $urandom_range(0, 1);
            mem_data = {$urandom, $urandom};
            @(negedge clk);
            chk("wr_hold", {stall, mem_wr_en, rd_valid, hit}, 4'b1100);
            chk("wr_hold_data", mem_wr_data, d);
        end
        mem_data_valid = 1'b0;
        mem_wr_ack = 1'b1;
        @(negedge clk);
        mem_wr_ack = 1'b0;
        chk("wr_done", {stall, mem_wr_en, rd_valid, hit}, 4'b0000);
        mem[word_of(a)] = d;
        if (pos >= 0) begin
            m_dat[s][pos] = d;
            model_touch(s, pos);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_flags"}, {rd_valid, hit, stall, mem_rd_en, mem_wr_en}, 5'b0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    initial begin
        bit h;
        logic [31:0] a;
        model_clear();
        mem[32'h40] = 64'hDEAD_BEEF_0000_0001;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        do_read(32'h40, h);
        chk("first_read_miss", h, 0);
        do_read(32'h40, h);
        chk("second_read_hit", h, 1);
        chk("second_read_data", rd_data, 64'hDEAD_BEEF_0000_0001);

        do_read(32'h440, h);
        chk("fill_440_miss", h, 0);
        do_read(32'h840, h);
        chk("fill_840_miss", h, 0);
        do_read(32'h440, h);
        chk("reread_440_hit", h, 1);
        do_read(32'h40, h);
        chk("reread_40_evicted", h, 0);

        do_write(32'h440, 64'h55, 1'b0, h);
        chk("write_440_hit", h, 1);
        do_read(32'h440, h);
        chk("read_440_after_write", h, 1);
        chk("read_440_data", rd_data, 64'h55);
        do_write(32'h1000, 64'h1234, 1'b1, h);
        chk("write_1000_miss", h, 0);
        do_read(32'h1000, h);
        chk("read_1000_no_alloc", h, 0);

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) * 128) + ($urandom_range(0, 3) * 8) + $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 2)
                do_write(a, {$urandom, $urandom}, $urandom_range(0, 3) == 0, h);
            else
                do_read(a, h);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_no_pulse", {rd_valid, hit, stall}, 3'b000);
                chk("idle_rd_stable", rd_data, last_rd);
            end
        end

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        addr = 32'h40;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("abort_miss_started", {stall, mem_rd_en}, 2'b11);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("abort_drop", {stall, mem_rd_en}, 2'b00);
        chk_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        mem_data = 64'hBAD0_BAD0_BAD0_BAD0;
        mem_data_valid = 1'b1;
        @(negedge clk);
        mem_data_valid = 1'b0;
        chk("late_strobe_ignored", {rd_valid, hit, stall, mem_rd_en}, 4'b0000);
        chk("late_strobe_rd_data", rd_data, 0);
        do_read(32'h40, h);
        chk("reread_40_after_reset", h, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 64, word width (multiple of 8); SETS, 16, sets (power of 2, >=2); WAYS fixed at 2.
REQ-002 SHALL have ports, in order:
  clk  in  1  clock, single clock domain
  rst  in  1  asynchronous, active-low reset
  addr  in  ADDR_W  CPU byte address
  rd_en  in  1  CPU read request
  wr_en  in  1  CPU write request
  wr_data  in  DATA_W  CPU write word
  rd_data  out  DATA_W  read word
  rd_valid  out  1  rd_data valid pulse
  hit  out  1  lookup-hit pulse
  stall  out  1  controller busy; requests ignored
  mem_rd_en  out  1  memory read request
  mem_wr_en  out  1  memory write request
  mem_addr  out  ADDR_W  word-aligned memory address
  mem_wr_data  out  DATA_W  memory write word
  mem_data  in  DATA_W  memory read word
  mem_data_valid  in  1  memory read return strobe
  mem_wr_ack  in  1  memory write done strobe

Function
REQ-003 SHALL split addr: offset = low log2(DATA_W/8) bits (ignored); index = next log2(SETS) bits; tag = remaining upper bits.
REQ-004 SHALL hold per set and way: valid bit, tag, one DATA_W word; per set: one LRU bit naming the least-recently-used way.
REQ-005 SHALL accept a request only on a rising edge in IDLE with stall=0; wr_en SHALL take priority when rd_en and wr_en are both 1.
REQ-006 SHALL latch addr and wr_data on accept; CPU inputs MAY change afterwards.
REQ-007 SHALL, on a read hit, drive rd_data = hit way's word with rd_valid=1 and hit=1 for exactly the one cycle after accept, set LRU to the other way, and remain in IDLE so back-to-back hits sustain one per cycle.
REQ-008 SHALL, on a read miss, go to MISS_RD at the accept edge, with stall=1, mem_rd_en=1 and mem_addr = addr with offset bits zeroed, all held until mem_data_valid.
REQ-009 SHALL, on mem_data_valid in MISS_RD: fill victim way (way 0 if invalid, else way 1 if invalid, else LRU way) with valid=1, tag and mem_data; set LRU to the other way; drive rd_data=mem_data with rd_valid=1 and hit=0 for one cycle; drop mem_rd_en and stall; return to IDLE, all at the same edge.
REQ-010 SHALL handle writes write-through, no-write-allocate: on a write hit, update the hit way's word and set LRU to the other way at the accept edge; on a write miss, leave the arrays unchanged.
REQ-011 SHALL, for every write, go to WR_MEM with stall=1, mem_wr_en=1, mem_addr aligned and mem_wr_data = latched wr_data, held until mem_wr_ack, then return to IDLE with stall=0 at that edge; hit SHALL pulse one cycle after accept on a write hit only.
REQ-012 SHALL ignore mem_data_valid outside MISS_RD and mem_wr_ack outside WR_MEM.
REQ-013 SHALL keep rd_data stable between rd_valid pulses; rd_valid and hit SHALL never exceed one cycle per request.
REQ-014 SHALL use states IDLE, MISS_RD, WR_MEM only; no other transitions.

Reset
REQ-015 SHALL, while rst=0, clear all valid and LRU bits, set state to IDLE, and drive rd_data=0, rd_valid=0, hit=0, stall=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, asynchronously.
REQ-016 SHALL abort any outstanding MISS_RD/WR_MEM on reset, with no fill; a late memory strobe after release SHALL be ignored.

Structure
REQ-017 SHALL take from package cache_pkg: the state enum, default parameter values, and index/tag extraction functions.
REQ-018 SHALL instantiate sub-module cache_way_array once per way, holding that way's valid, tag and data arrays, with one write port and a combinational read port.

Verification
REQ-019 Reset, then read 0x0000_0040 -> miss: mem_rd_en=1, mem_addr=0x40; return 0xDEAD_BEEF_0000_0001 -> rd_valid=1, hit=0, stall=0.
REQ-020 Repeat read 0x40 -> next cycle hit=1, rd_valid=1, rd_data=0xDEAD_BEEF_0000_0001, mem_rd_en stays 0.
REQ-021 Fill 0x40, 0x440 and 0x840 (same set, SETS=16) -> third fill evicts 0x40; re-read 0x440 is a hit; re-read 0x40 is a miss.
REQ-022 Write 0x55 to 0x440 (hit) -> hit=1, mem_wr_en/mem_wr_data=0x55 until ack; next read 0x440 hits with 0x55. Write to uncached 0x1000 -> hit=0, no allocate.
REQ-023 Assert rst=0 mid-MISS_RD -> mem_rd_en and stall drop immediately; a mem_data_valid after release is ignored; re-read 0x40 misses.
